rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 119 +++++++++++
 tb/tb_rom_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one synchronous ROM between an instruction port and a
// data port.
//
// Each ROM access goes IDLE -> ACCESS (WAIT_STATES+1 cycles) -> ACK.
// - IDLE picks a port and latches its address.
// - ACCESS holds radr_o/STB_o steady. On its last cycle the ROM word is
//   captured into the granted port's data register.
// - ACK raises the granted port's ack for one cycle, but only if that port
//   is still strobing. Then the FSM returns to IDLE.
// When both ports request in IDLE, the port that was not granted last wins.
//
// Handshake: a port requests by holding its strobe high. Its ack is high for
// exactly one cycle, and the read data is valid in that cycle. If the strobe
// is dropped before ACK, the access still completes but no ack is given. If
// the strobe is still high after the ack, that is a new request.
//
// Ports
//   clk_i, reset_i   clock and synchronous active-high reset
//   iadr_i, istb_i   instruction-port address / request strobe
//   iack_o, idat_o   instruction-port acknowledge / read data
//   dadr_i, dstb_i   data-port address / request strobe
//   dack_o, ddat_o   data-port acknowledge / read data
//   radr_o, STB_o    ROM address / strobe
//   rdat_i           ROM read data
//   state_o          current FSM state (0 IDLE, 1 ACCESS, 2 ACK) for debug

module rom_arbiter #(
    parameter int AW          = 12,
    parameter int DW          = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [AW-1:0] iadr_i,
    input  logic          istb_i,
    output logic          iack_o,
    output logic [DW-1:0] idat_o,
    input  logic [AW-1:0] dadr_i,
    input  logic          dstb_i,
    output logic          dack_o,
    output logic [DW-1:0] ddat_o,
    output logic [AW-1:0] radr_o,
    output logic          STB_o,
    input  logic [DW-1:0] rdat_i,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       grant;       // 0 = instruction port, 1 = data port
    logic       last_grant;  // port served by the most recent completed access
    logic       pick_data;

    // The data port wins if it is the only requester. Under contention it
    // also wins when the instruction port was the one served last.
    always_comb begin
        pick_data  = dstb_i && (!istb_i || !last_grant);
        state_next = state;
        case (state)
            IDLE:    if (istb_i || dstb_i) state_next = ACCESS;
            ACCESS:  if (count == 4'd0) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Ack is gated by the live strobe, so a strobe dropped mid-access
        // suppresses the ack.
        iack_o = (state == ACK) && !grant && istb_i;
        dack_o = (state == ACK) &&  grant && dstb_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count      <= 4'd0;
            grant      <= 1'b0;
            last_grant <= 1'b0;
            radr_o     <= '0;
            STB_o      <= 1'b0;
            idat_o     <= '0;
            ddat_o     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (istb_i || dstb_i) begin
                        grant  <= pick_data;
                        radr_o <= pick_data ? dadr_i : iadr_i;
                        STB_o  <= 1'b1;
                        count  <= 4'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (grant) ddat_o <= rdat_i;
                        else       idat_o <= rdat_i;
                        STB_o <= 1'b0;
                    end
                end
                ACK: last_grant <= grant;
                default: ;
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed testbench for rom_arbiter. Instance a uses WAIT_STATES=2 and
// instance b uses WAIT_STATES=0.

module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] iadr, dadr, b_iadr, b_dadr;
    logic        istb, dstb, b_istb, b_dstb;
    logic [31:0] rdat, b_rdat;

    logic        a_iack, a_dack, a_stb, b_iack, b_dack, b_stb;
    logic [31:0] a_idat, a_ddat, b_idat, b_ddat;
    logic [11:0] a_radr, b_radr;
    logic [1:0]  a_state, b_state;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.AW(12), .DW(32), .WAIT_STATES(2)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .iadr_i(iadr), .istb_i(istb), .iack_o(a_iack), .idat_o(a_idat),
        .dadr_i(dadr), .dstb_i(dstb), .dack_o(a_dack), .ddat_o(a_ddat),
        .radr_o(a_radr), .STB_o(a_stb), .rdat_i(rdat), .state_o(a_state)
    );

    rom_arbiter #(.AW(12), .DW(32), .WAIT_STATES(0)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .iadr_i(b_iadr), .istb_i(b_istb), .iack_o(b_iack), .idat_o(b_idat),
        .dadr_i(b_dadr), .dstb_i(b_dstb), .dack_o(b_dack), .ddat_o(b_ddat),
        .radr_o(b_radr), .STB_o(b_stb), .rdat_i(b_rdat), .state_o(b_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1 ns after the rising edge; outputs are checked 3 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    initial begin
        reset = 1'b1;
        iadr = '0; dadr = '0; istb = 1'b0; dstb = 1'b0; rdat = '0;
        b_iadr = '0; b_dadr = '0; b_istb = 1'b0; b_dstb = 1'b0; b_rdat = '0;

        // Reset state
        tick(); tick(); look();
        chk("rst_stb", a_stb, 0);   chk("rst_iack", a_iack, 0); chk("rst_dack", a_dack, 0);
        chk("rst_radr", a_radr, 0); chk("rst_idat", a_idat, 0); chk("rst_ddat", a_ddat, 0);
        chk("rst_state", a_state, 0);
        chk("rst_b_stb", b_stb, 0); chk("rst_b_dack", b_dack, 0); chk("rst_b_state", b_state, 0);

        // Both strobes held from reset: data, then instruction, then data.
        // Acks are expected in cycles 5, 10 and 15.
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 1) begin
                reset = 1'b0; istb = 1'b1; dstb = 1'b1;
                iadr = 12'h0AA; dadr = 12'h0BB; rdat = 32'hD0D0_D0D0;
            end
            if (k == 6) rdat = 32'h1A1A_1A1A;
            look();
            chk($sformatf("rr_dack_c%0d", k), a_dack, (k == 5 || k == 15) ? 1 : 0);
            chk($sformatf("rr_iack_c%0d", k), a_iack, (k == 10) ? 1 : 0);
            if (k == 2)  chk("rr_radr_c2", a_radr, 12'h0BB);
            if (k == 7)  chk("rr_radr_c7", a_radr, 12'h0AA);
            if (k == 12) chk("rr_radr_c12", a_radr, 12'h0BB);
            if (k == 5)  chk("rr_ddat_c5", a_ddat, 32'hD0D0_D0D0);
            if (k == 10) chk("rr_idat_c10", a_idat, 32'h1A1A_1A1A);
        end
        tick(); istb = 1'b0; dstb = 1'b0;

        // Single instruction read at address 0x123 with ack in cycle 5
        tick(); istb = 1'b1; iadr = 12'h123; rdat = 32'hDEAD_BEEF; look();
        chk("i_c1_stb", a_stb, 0); chk("i_c1_iack", a_iack, 0);
        for (int k = 2; k <= 4; k++) begin
            tick(); look();
            chk($sformatf("i_c%0d_stb", k), a_stb, 1);
            chk($sformatf("i_c%0d_radr", k), a_radr, 12'h123);
            chk($sformatf("i_c%0d_iack", k), a_iack, 0);
        end
        tick(); look();
        chk("i_c5_stb", a_stb, 0); chk("i_c5_iack", a_iack, 1);
        chk("i_c5_idat", a_idat, 32'hDEAD_BEEF); chk("i_c5_state", a_state, 2);
        tick(); istb = 1'b0; look();
        chk("i_c6_iack", a_iack, 0); chk("i_c6_state", a_state, 0); chk("i_c6_idat", a_idat, 32'hDEAD_BEEF);

        // A change to iadr during ACCESS is ignored
        tick(); istb = 1'b1; iadr = 12'h010; rdat = 32'h1111_1111;
        tick(); iadr = 12'h020; look(); chk("adr_c2", a_radr, 12'h010);
        tick(); look(); chk("adr_c3", a_radr, 12'h010);
        tick(); look(); chk("adr_c4", a_radr, 12'h010);
        tick(); look(); chk("adr_c5_iack", a_iack, 1); chk("adr_c5_idat", a_idat, 32'h1111_1111);
        tick(); istb = 1'b0;

        // Data read; this leaves last-grant pointing at the data port
        tick(); dstb = 1'b1; dadr = 12'h077; rdat = 32'h3333_3333;
        tick(); tick(); tick();
        tick(); look();
        chk("d_c5_dack", a_dack, 1); chk("d_c5_iack", a_iack, 0); chk("d_c5_ddat", a_ddat, 32'h3333_3333);
        tick(); dstb = 1'b0;

        // istb dropped during ACCESS: full STB window, no ack
        tick(); istb = 1'b1; iadr = 12'h055; rdat = 32'h2222_2222;
        tick(); istb = 1'b0; look(); chk("drop_c2_stb", a_stb, 1);
        tick(); look(); chk("drop_c3_stb", a_stb, 1);
        tick(); look(); chk("drop_c4_stb", a_stb, 1);
        tick(); look();
        chk("drop_c5_stb", a_stb, 0); chk("drop_c5_iack", a_iack, 0);
        chk("drop_c5_state", a_state, 2); chk("drop_c5_idat", a_idat, 32'h2222_2222);
        tick(); look(); chk("drop_c6_state", a_state, 0);

        // Last-grant was updated to instruction, so data wins this contention
        tick(); istb = 1'b1; dstb = 1'b1; iadr = 12'h0AA; dadr = 12'h0BB;
        tick(); istb = 1'b0; dstb = 1'b0; look(); chk("rr2_radr", a_radr, 12'h0BB);
        tick(); tick();
        tick(); look();
        chk("rr2_dack", a_dack, 0); chk("rr2_iack", a_iack, 0); chk("rr2_ddat", a_ddat, 32'h2222_2222);
        tick();

        // Reset pulsed in the second ACCESS cycle
        tick(); istb = 1'b1; iadr = 12'h03C; rdat = 32'h5555_5555;
        tick();
        tick(); reset = 1'b1; look(); chk("ra_c3_stb", a_stb, 1); chk("ra_c3_state", a_state, 1);
        tick(); reset = 1'b0; istb = 1'b0; look();
        chk("ra_stb", a_stb, 0);   chk("ra_iack", a_iack, 0); chk("ra_dack", a_dack, 0);
        chk("ra_radr", a_radr, 0); chk("ra_idat", a_idat, 0); chk("ra_ddat", a_ddat, 0);
        chk("ra_state", a_state, 0);
        for (int k = 5; k <= 7; k++) begin
            tick(); look();
            chk($sformatf("ra_c%0d_iack", k), a_iack, 0);
            chk($sformatf("ra_c%0d_state", k), a_state, 0);
        end

        // WAIT_STATES=0 with dstb held. The ack comes every 3 cycles and
        // carries the ROM data from the ACCESS cycle.
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 1) begin
                b_dstb = 1'b1; b_dadr = 12'h005;
            end
            b_rdat = 32'h100 + 32'(k);
            look();
            chk($sformatf("ws0_dack_c%0d", k), b_dack, (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) chk($sformatf("ws0_ddat_c%0d", k), b_ddat, 32'h100 + 32'(k - 1));
            if (k % 3 == 2) chk($sformatf("ws0_radr_c%0d", k), b_radr, 12'h005);
        end
        tick(); b_dstb = 1'b0;
        tick(); look(); chk("ws0_end_dack", b_dack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
